// File: rtl/cache_pkg.sv
// cache_pkg: refill FSM state encoding and line-geometry helper shared by both caches
package cache_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  function automatic int off_bits(input int words);
    return $clog2(words);
  endfunction
endpackage

// File: rtl/cache_refill.sv
// cache_refill: fetches one cache line word-by-word into the data SRAM and forwards the missed word
// CRITICAL_WORD_FIRST_EN: start at the missed word and wrap through the line instead of starting at word 0
module cache_refill
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [31:0]           mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                  mem_rsp_err,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  sram_we,
  output logic                  crit_valid,
  output logic [DATA_WIDTH-1:0] crit_data,
  output logic                  done,
  output logic                  err
);
  localparam int OB = off_bits(WORDS_PER_LINE);
  state_t state, state_nx;
  logic [31:2] addr;
  logic [OB-1:0] cnt, cnt_nx, off, start_in, start_q;
  logic err_q, rsp_ok, last;
  assign off = addr[OB+1:2];
`ifdef CRITICAL_WORD_FIRST_EN
  assign start_in = req_addr[OB+1:2];
  assign start_q  = off;
`else
  assign start_in = '0;
  assign start_q  = '0;
`endif
  // the line is complete once the wrapping counter comes back to where it started
  assign cnt_nx = cnt + 1'b1;
  assign last   = cnt_nx == start_q;
  assign rsp_ok = state == RESP && mem_rsp_valid && !mem_rsp_err;
  always_comb begin
    state_nx = state == IDLE ? (req_valid ? REQ : IDLE)
             : state == REQ  ? (mem_req_ready ? RESP : REQ)
             : state == RESP ? (!mem_rsp_valid ? RESP : (mem_rsp_err || last) ? DONE : REQ)
             : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        addr  <= req_addr[31:2];
        cnt   <= start_in;
        err_q <= 1'b0;
      end
      if (rsp_ok) cnt <= cnt_nx;
      if (state == RESP && mem_rsp_valid && mem_rsp_err) err_q <= 1'b1;
    end
  end
  assign req_ready     = state == IDLE;
  assign mem_req_valid = state == REQ;
  assign mem_req_addr  = {addr[31:OB+2], cnt, 2'b00};
  assign sram_we       = rsp_ok;
  assign sram_addr     = {addr[ADDR_WIDTH+1:OB+2], cnt};
  assign sram_wdata    = rsp_ok ? mem_rsp_data : '0;
  assign crit_valid    = rsp_ok && cnt == off;
  assign crit_data     = crit_valid ? mem_rsp_data : '0;
  assign done          = state == DONE;
  assign err           = done && err_q;
endmodule
